hzu_mt: RTL and testbench
=========================

# hzu_mt

Multi-thread, parametrised hazard unit between fetch and decode/issue. It keeps a shifting history of the last DEPTH issued instructions tagged by thread, and blocks each candidate instruction on a same-thread RAW hazard, a memory-after-store conflict, a fetch exception or a thread flush. Writeback-driven early release and per-thread flush are new compared with the previous generation. A saturating stall counter is exported for performance monitoring.

## Interface

Parameters:
- DEPTH, 8: history entries, ≥2; an issued instruction ages out after DEPTH cycles.
- THREADS, 4: hardware threads, ≥2; thread id width TID_W = $clog2(THREADS).
- REG_W, 5: register id width; register 0 is hardwired zero and never hazards.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low; state clears on a rising clk edge while rst=0.
- in_valid  in  1  candidate instruction present.
- in_thread  in  TID_W  candidate thread.
- in_src1, in_src2  in  REG_W  candidate source registers.
- in_dst  in  REG_W  candidate destination.
- in_has_dst  in  1  candidate writes in_dst.
- in_is_store, in_is_load  in  1  memory op class (stb/stw, ldb/ldw).
- itlb_miss, icache_miss  in  1  fetch exception for the candidate.
- wb_valid, wb_thread, wb_dst  in  1/TID_W/REG_W  writeback of a register this cycle.
- flush_valid, flush_thread  in  1/TID_W  squash all history of a thread.
- issue  out  1  candidate accepted this cycle (combinational).
- stall  out  1  in_valid=1 and blocked by hazard (RAW or mem), not by exception or flush.
- stall_count  out  CNT_W  registered saturating count of stall cycles.

## Operation

- History entry: valid, thread, dst, has_dst, is_store. Entry 0 is the newest.
- RAW hit: any entry i with valid, thread==in_thread, has_dst, dst!=0, and dst==in_src1 or dst==in_src2. Entries matching the same-cycle writeback (wb_valid, wb_thread, wb_dst) are excluded.
- Mem hit: entry 0 valid, entry 0 is_store, and the candidate is_store or is_load. Thread is ignored; this is a shared-port restriction.
- Flush hit: flush_valid and flush_thread==in_thread.
- Fetch exception: itlb_miss or icache_miss.
- Outputs:
  - issue = in_valid & !RAW & !Mem & !flush hit & !fetch exception.
  - stall = in_valid & (RAW | Mem) & !flush hit & !fetch exception.
- Edge update, applied in this order:
  1. Writeback clear: every valid entry matching wb_thread/wb_dst with has_dst gets has_dst=0. All matches are cleared.
  2. Flush: every entry with thread==flush_thread gets valid=0.
  3. Shift: entry i+1 ← entry i; entry DEPTH-1 is discarded.
  4. Entry 0 loads the candidate fields with valid=issue. A non-issued cycle inserts a bubble.
- stall_count increments by 1 on each cycle with stall=1 and holds at 2^CNT_W−1.
- Candidates are not queued. Fetch re-presents a non-issued instruction.

## Timing

- Reset (rst=0 at edge): all entries valid=0, stall_count=0. While rst=0, issue=0 and stall=0, forced combinationally; no history writes and no counter increments.
- Reset deasserted mid-stream: the first cycle after reset sees an empty history, so any candidate without an exception issues.
- Issue decision: zero-cycle latency. A dependent instruction of the same thread sees its producer from the very next cycle.
- RAW release: DEPTH cycles after the producer issues, or in the cycle wb names it, whichever is first.
- Mem hit lasts exactly one cycle after a store issues, because the bubble clears entry 0.
- Simultaneous events:
  - Flush and candidate of the same thread: not issued; no stall count.
  - Writeback and candidate in the same cycle: the writeback releases the hazard.
  - Flush of another thread: no effect on the candidate.
- stall_count is visible one cycle after the stalled cycle.

## Test plan

- Reset then idle: rst=0 for 2 cycles with in_valid=1 → issue=0, stall_count=0. After release, thread 0 `add r3` issues with issue=1.
- RAW ageing: thread 1 issues dst=r5; next cycle, thread 1 with src1=r5 and no wb → stall=1 for 7 cycles, then issue=1 on the 8th (DEPTH=8); stall_count=7.
- Cross-thread and r0: thread 2 dst=r5 then thread 3 src2=r5 → issue immediately. Any thread with dst=r0 then src1=r0 → issue immediately.
- Writeback release: thread 0 dst=r7, then thread 0 src1=r7 stalls 2 cycles; in the 3rd cycle wb_valid=1, wb_thread=0, wb_dst=7 → issue=1 in that same cycle.
- Store conflict: thread 0 stw issues, then thread 1 ldw → stall=1 for 1 cycle, issue the next. Two consecutive stw → second is stalled one cycle.
- Exception and flush: icache_miss=1 with a RAW hazard present → issue=0, stall=0, counter unchanged. flush_valid=1 for thread 1 while a thread 1 dependent is waiting → the next cycle it issues.

Source files
------------

// File: rtl/hzu_mt.sv
// Multi-thread issue hazard unit: per-thread RAW tracking over a shifting issue
// history, shared memory-port store conflict, fetch exceptions and thread flush.
module hzu_mt #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned THREADS = 4,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned TID_W  = $clog2(THREADS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TID_W-1:0] in_thread,
  input  logic [REG_W-1:0] in_src1,
  input  logic [REG_W-1:0] in_src2,
  input  logic [REG_W-1:0] in_dst,
  input  logic             in_has_dst,
  input  logic             in_is_store,
  input  logic             in_is_load,
  input  logic             itlb_miss,
  input  logic             icache_miss,
  input  logic             wb_valid,
  input  logic [TID_W-1:0] wb_thread,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             flush_valid,
  input  logic [TID_W-1:0] flush_thread,
  output logic             issue,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  // The candidate itself is the newest of the last DEPTH instructions, so only
  // DEPTH-1 older issues are stored: a producer blocks for DEPTH-1 cycles after issue.
  localparam int unsigned HD = DEPTH - 1;

  typedef struct packed {
    logic             valid;
    logic [TID_W-1:0] thread;
    logic [REG_W-1:0] dst;
    logic             has_dst;
    logic             is_store;
  } entry_t;

  entry_t hist_q [HD];
  entry_t hist_n [HD];

  logic raw_hit;
  logic mem_hit;
  logic flush_hit;
  logic fetch_exc;

  // Writeback clears the pending destination, then a flush kills the thread's entries.
  function automatic entry_t age_entry(input entry_t e,
                                       input logic wbv, input logic [TID_W-1:0] wbt,
                                       input logic [REG_W-1:0] wbd,
                                       input logic flv, input logic [TID_W-1:0] flt);
    entry_t r;
    r = e;
    if (wbv && r.valid && r.has_dst && r.thread == wbt && r.dst == wbd) r.has_dst = 1'b0;
    if (flv && r.thread == flt) r.valid = 1'b0;
    return r;
  endfunction

  always_comb begin
    raw_hit = 1'b0;
    for (int unsigned i = 0; i < HD; i++) begin
      if (hist_q[i].valid && hist_q[i].has_dst && hist_q[i].thread == in_thread &&
          hist_q[i].dst != '0 &&
          (hist_q[i].dst == in_src1 || hist_q[i].dst == in_src2) &&
          !(wb_valid && wb_thread == hist_q[i].thread && wb_dst == hist_q[i].dst))
        raw_hit = 1'b1;
    end
  end

  // Memory conflict ignores thread: the data port is shared.
  assign mem_hit   = hist_q[0].valid && hist_q[0].is_store && (in_is_store || in_is_load);
  assign flush_hit = flush_valid && flush_thread == in_thread;
  assign fetch_exc = itlb_miss || icache_miss;

  assign issue = rst && in_valid && !raw_hit && !mem_hit && !flush_hit && !fetch_exc;
  assign stall = rst && in_valid && (raw_hit || mem_hit) && !flush_hit && !fetch_exc;

  always_comb begin
    hist_n[0] = '{valid: issue, thread: in_thread, dst: in_dst,
                  has_dst: in_has_dst, is_store: in_is_store};
    for (int unsigned i = 1; i < HD; i++)
      hist_n[i] = age_entry(hist_q[i-1], wb_valid, wb_thread, wb_dst, flush_valid, flush_thread);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < HD; i++) hist_q[i] <= '0;
      stall_count <= '0;
    end else begin
      hist_q <= hist_n;
      if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hzu_mt.sv
// Directed bench for hzu_mt: reset, RAW ageing, cross-thread/r0, writeback
// release, store conflicts, fetch exception and flush interactions.
module tb_hzu_mt;

  localparam int unsigned TID_W = 2;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [TID_W-1:0] in_thread;
  logic [REG_W-1:0] in_src1, in_src2, in_dst;
  logic             in_has_dst, in_is_store, in_is_load;
  logic             itlb_miss, icache_miss;
  logic             wb_valid;
  logic [TID_W-1:0] wb_thread;
  logic [REG_W-1:0] wb_dst;
  logic             flush_valid;
  logic [TID_W-1:0] flush_thread;
  logic             issue, stall;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hzu_mt #(.DEPTH(8), .THREADS(4), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_thread(in_thread),
    .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst),
    .in_has_dst(in_has_dst), .in_is_store(in_is_store), .in_is_load(in_is_load),
    .itlb_miss(itlb_miss), .icache_miss(icache_miss),
    .wb_valid(wb_valid), .wb_thread(wb_thread), .wb_dst(wb_dst),
    .flush_valid(flush_valid), .flush_thread(flush_thread),
    .issue(issue), .stall(stall), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a candidate; side-band inputs return to idle.
  task automatic set_op(input logic v, input int t, input int s1, input int s2, input int d,
                        input logic hd, input logic st, input logic ld);
    in_valid     = v;
    in_thread    = TID_W'(t);
    in_src1      = REG_W'(s1);
    in_src2      = REG_W'(s2);
    in_dst       = REG_W'(d);
    in_has_dst   = hd;
    in_is_store  = st;
    in_is_load   = ld;
    itlb_miss    = 1'b0;
    icache_miss  = 1'b0;
    wb_valid     = 1'b0;
    wb_thread    = '0;
    wb_dst       = '0;
    flush_valid  = 1'b0;
    flush_thread = '0;
  endtask

  // Check combinational outputs mid-cycle, then advance to the next falling edge.
  task automatic expect_out(input string tag, input logic exp_issue, input logic exp_stall);
    #1;
    chk({tag, "_issue"}, 32'(issue), 32'(exp_issue));
    chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    set_op(1'b1, 0, 1, 2, 3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("rst0", 1'b0, 1'b0);
    expect_out("rst1", 1'b0, 1'b0);
    chk("rst_count", 32'(stall_count), 32'd0);

    rst = 1'b1;
    set_op(1'b1, 0, 1, 2, 3, 1'b1, 1'b0, 1'b0);
    expect_out("first_add", 1'b1, 1'b0);

    // RAW ageing: producer visible for 7 cycles
    set_op(1'b1, 1, 0, 0, 5, 1'b1, 1'b0, 1'b0);
    expect_out("raw_prod", 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      set_op(1'b1, 1, 5, 0, 0, 1'b0, 1'b0, 1'b0);
      expect_out("raw_age_stall", 1'b0, 1'b1);
    end
    set_op(1'b1, 1, 5, 0, 0, 1'b0, 1'b0, 1'b0);
    expect_out("raw_age_issue", 1'b1, 1'b0);
    chk("raw_age_count", 32'(stall_count), 32'd7);

    set_op(1'b1, 2, 0, 0, 5, 1'b1, 1'b0, 1'b0);
    expect_out("xthr_prod", 1'b1, 1'b0);
    set_op(1'b1, 3, 0, 5, 0, 1'b0, 1'b0, 1'b0);
    expect_out("xthr_cons", 1'b1, 1'b0);
    set_op(1'b1, 1, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    expect_out("r0_prod", 1'b1, 1'b0);
    set_op(1'b1, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    expect_out("r0_cons", 1'b1, 1'b0);

    // Writeback release in the same cycle
    set_op(1'b1, 0, 0, 0, 7, 1'b1, 1'b0, 1'b0);
    expect_out("wb_prod", 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      set_op(1'b1, 0, 7, 0, 0, 1'b0, 1'b0, 1'b0);
      expect_out("wb_wait", 1'b0, 1'b1);
    end
    set_op(1'b1, 0, 7, 0, 0, 1'b0, 1'b0, 1'b0);
    wb_valid = 1'b1; wb_thread = 2'd0; wb_dst = 5'd7;
    expect_out("wb_release", 1'b1, 1'b0);
    chk("wb_count", 32'(stall_count), 32'd9);

    // Store followed by load on another thread, then back-to-back stores
    set_op(1'b1, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    expect_out("stw0", 1'b1, 1'b0);
    set_op(1'b1, 1, 0, 0, 9, 1'b1, 1'b0, 1'b1);
    expect_out("ldw_stall", 1'b0, 1'b1);
    set_op(1'b1, 1, 0, 0, 9, 1'b1, 1'b0, 1'b1);
    expect_out("ldw_issue", 1'b1, 1'b0);
    set_op(1'b1, 2, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    expect_out("stw_a", 1'b1, 1'b0);
    set_op(1'b1, 2, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    expect_out("stw_b_stall", 1'b0, 1'b1);
    set_op(1'b1, 2, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    expect_out("stw_b_issue", 1'b1, 1'b0);
    chk("mem_count", 32'(stall_count), 32'd11);
    set_op(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    expect_out("idle_after_stw", 1'b0, 1'b0);

    // Fetch exception masks a real RAW hazard
    set_op(1'b1, 3, 0, 0, 4, 1'b1, 1'b0, 1'b0);
    expect_out("exc_prod", 1'b1, 1'b0);
    set_op(1'b1, 3, 4, 0, 0, 1'b0, 1'b0, 1'b0);
    icache_miss = 1'b1;
    expect_out("exc_icmiss", 1'b0, 1'b0);
    chk("exc_count", 32'(stall_count), 32'd11);
    set_op(1'b1, 3, 4, 0, 0, 1'b0, 1'b0, 1'b0);
    expect_out("exc_then_stall", 1'b0, 1'b1);
    chk("exc_count2", 32'(stall_count), 32'd12);

    // Flush of the waiting thread clears its history
    set_op(1'b1, 1, 0, 0, 6, 1'b1, 1'b0, 1'b0);
    expect_out("fl_prod", 1'b1, 1'b0);
    set_op(1'b1, 1, 6, 0, 0, 1'b0, 1'b0, 1'b0);
    expect_out("fl_wait", 1'b0, 1'b1);
    set_op(1'b1, 1, 6, 0, 0, 1'b0, 1'b0, 1'b0);
    flush_valid = 1'b1; flush_thread = 2'd1;
    expect_out("fl_same", 1'b0, 1'b0);
    chk("fl_count", 32'(stall_count), 32'd13);
    set_op(1'b1, 1, 6, 0, 0, 1'b0, 1'b0, 1'b0);
    expect_out("fl_after", 1'b1, 1'b0);
    set_op(1'b1, 2, 0, 0, 8, 1'b1, 1'b0, 1'b0);
    expect_out("fl_prod2", 1'b1, 1'b0);
    set_op(1'b1, 3, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    flush_valid = 1'b1; flush_thread = 2'd2;
    expect_out("fl_other", 1'b1, 1'b0);
    set_op(1'b1, 2, 8, 0, 0, 1'b0, 1'b0, 1'b0);
    expect_out("fl_other_after", 1'b1, 1'b0);

    // Reset mid-stream empties the history and the counter
    set_op(1'b1, 0, 0, 0, 10, 1'b1, 1'b0, 1'b0);
    expect_out("mid_prod", 1'b1, 1'b0);
    rst = 1'b0;
    set_op(1'b1, 0, 10, 0, 0, 1'b0, 1'b0, 1'b0);
    expect_out("mid_rst", 1'b0, 1'b0);
    chk("mid_rst_count", 32'(stall_count), 32'd0);
    rst = 1'b1;
    set_op(1'b1, 0, 10, 0, 0, 1'b0, 1'b0, 1'b0);
    expect_out("mid_after", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
